seg7_mux_n: RTL

SEG7_MUX_N -- requirements
Module: seg7_mux_n

---
 rtl/seg7_mux_n.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg7_mux_n.sv
// Time-multiplexed NDIG-digit hex seven-segment driver with frame-aligned
// double-buffered loads, per-digit blanking, leading-zero suppression and dead-time.
module seg7_mux_n #(
    parameter int NDIG      = 4,
    parameter int DIV       = 333334,
    parameter int BLANK_CYC = 16,
    localparam int SW       = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   blank_mask,
    input  logic              lz_suppress,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic [SW-1:0]     sel,
    output logic              frame
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(NDIG - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h18;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h27;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [4*NDIG-1:0] shd_dig_q, shd_dig_d, act_dig_q, act_dig_d;
    logic [NDIG-1:0]   shd_blk_q, shd_blk_d, act_blk_q, act_blk_d;
    logic              pend_q, pend_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              frame_w;
    logic [NDIG-1:0]   lz_vec;
    logic              upper_zero;
    logic [3:0]        nib;
    logic              dark;

    assign frame_w = (cnt_q == CNT_LAST) && (sel_q == SEL_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    // Active registers only change at the frame boundary so a frame never tears.
    always_comb begin
        shd_dig_d = shd_dig_q;
        shd_blk_d = shd_blk_q;
        act_dig_d = act_dig_q;
        act_blk_d = act_blk_q;
        pend_d    = pend_q;
        if (load && frame_w) begin
            shd_dig_d = digits;
            shd_blk_d = blank_mask;
            act_dig_d = digits;
            act_blk_d = blank_mask;
            pend_d    = 1'b0;
        end else begin
            if (frame_w && pend_q) begin
                act_dig_d = shd_dig_q;
                act_blk_d = shd_blk_q;
                pend_d    = 1'b0;
            end
            if (load) begin
                shd_dig_d = digits;
                shd_blk_d = blank_mask;
                pend_d    = 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        lz_vec     = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_dig_q[4*i +: 4] == 4'h0);
            lz_vec[i]  = lz_suppress && (i > 0) && upper_zero;
        end
    end

    always_comb begin
        nib  = act_dig_q[4*int'(sel_q) +: 4];
        dark = (int'(cnt_q) < BLANK_CYC) || act_blk_q[sel_q] || lz_vec[sel_q];
        an_d  = dark ? '1 : ~(NDIG'(1) << sel_q);
        seg_d = dark ? 7'h7F : hex7(nib);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            sel_q     <= '0;
            shd_dig_q <= '0;
            shd_blk_q <= '0;
            act_dig_q <= '0;
            act_blk_q <= '0;
            pend_q    <= 1'b0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            shd_dig_q <= shd_dig_d;
            shd_blk_q <= shd_blk_d;
            act_dig_q <= act_dig_d;
            act_blk_q <= act_blk_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign sel   = sel_q;
    assign frame = frame_w;

endmodule
